adder_sweep_checker: RTL and testbench

ADDER_SWEEP_CHECKER -- requirements
Module: adder_sweep_checker

---
 rtl/adder_sweep_checker.sv | 185 ++++++++++++++++++
 tb/tb_adder_sweep_checker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_sweep_checker.sv
// -----------------------------------------------------------------------------
// adder_sweep_checker
//
// Purpose
//   Exhaustively sweeps every operand combination of an external WIDTH-bit
//   adder, waits DUT_LAT cycles per vector for the adder to settle, and
//   compares the returned {carry,sum} with a golden a+b. It reports a pass
//   flag, a saturating mismatch count and the operands of the first
//   mismatching vector.
//
// Parameters
//   WIDTH    operand width of the adder under test (1..8)
//   DUT_LAT  cycles from an applied vector to valid adder outputs (0..7)
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset (wins over start)
//   start      in   one-cycle sweep request, sampled only in IDLE
//   a, b       out  registered operands to the adder (0 while idle)
//   cin        out  registered carry-in, only with ADDER_SWEEP_CIN_EN
//   sum        in   sum from the adder
//   carry      in   carry-out from the adder
//   busy       out  high while a sweep is running
//   done       out  one-cycle pulse at sweep completion
//   pass       out  last completed sweep had no mismatches
//   err_count  out  saturating mismatch count
//   fail_a/b   out  operands of the first mismatching vector, 0 if none
//
// Build option
//   ADDER_SWEEP_CIN_EN  adds the cin output; the vector index widens to
//                       {a,b,cin} and the golden value becomes a+b+cin.
// -----------------------------------------------------------------------------
module adder_sweep_checker #(
  parameter int WIDTH   = 4,
  parameter int DUT_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
`ifdef ADDER_SWEEP_CIN_EN
  output logic             cin,
`endif
  input  logic [WIDTH-1:0] sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

`ifdef ADDER_SWEEP_CIN_EN
  localparam int CIN_W = 1;
`else
  localparam int CIN_W = 0;
`endif
  localparam int IDX_W = 2 * WIDTH + CIN_W;

  // Last value of the settle counter before moving on to CHECK. Only used
  // when DUT_LAT > 0, since APPLY is skipped entirely otherwise.
  localparam logic [2:0] LAT_LAST = 3'(DUT_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    FINISH
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [2:0]         lat_cnt;

  logic               vec_cin;
  logic [WIDTH:0]     observed;
  logic [WIDTH:0]     expected;
  logic               mismatch;
  logic [15:0]        err_next;
  logic               idx_last;

  // Golden sum at WIDTH+1 bits so the carry-out is captured.
  function automatic logic [WIDTH:0] golden(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y,
                                            input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  // The operands come straight off the index register, so they are
  // registered and return to zero whenever the index is cleared.
  assign a = idx[IDX_W-1 -: WIDTH];
  assign b = idx[IDX_W-1-WIDTH -: WIDTH];

`ifdef ADDER_SWEEP_CIN_EN
  assign cin     = idx[0];
  assign vec_cin = idx[0];
`else
  assign vec_cin = 1'b0;
`endif

  assign observed = {carry, sum};
  assign expected = golden(a, b, vec_cin);
  assign mismatch = (observed != expected);
  assign err_next = mismatch ? sat_inc(err_count) : err_count;
  assign idx_last = &idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      lat_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            pass      <= 1'b0;
            idx       <= '0;
            lat_cnt   <= '0;
            busy      <= 1'b1;
            // With no adder latency the first vector is checked in the
            // very cycle it is presented.
            state     <= (DUT_LAT == 0) ? CHECK : APPLY;
          end
        end

        APPLY: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= '0;
            state   <= CHECK;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end

        CHECK: begin
          err_count <= err_next;
          // err_count never returns to zero once it has counted, so a zero
          // count marks the first mismatch of the sweep.
          if (mismatch && (err_count == 16'd0)) begin
            fail_a <= a;
            fail_b <= b;
          end
          if (idx_last) begin
            // Results are settled on the same edge the FINISH cycle starts,
            // so pass and done appear together with busy dropping.
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 16'd0);
            state <= FINISH;
          end else begin
            idx   <= idx + 1'b1;
            state <= (DUT_LAT == 0) ? CHECK : APPLY;
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sweep_checker.sv
module tb_adder_sweep_checker;

  localparam int W = 2;
`ifdef ADDER_SWEEP_CIN_EN
  localparam int NVEC      = 32;
  localparam int ERR_STUCK = 16;
  localparam int FA_STUCK  = 0;
`else
  localparam int NVEC      = 16;
  localparam int ERR_STUCK = 6;
  localparam int FA_STUCK  = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start;
  int   fault;

  int nchk  = 0;
  int npass = 0;

  // u0: combinational adder with selectable faults
  logic [W-1:0] a0, b0, sum0, fa0, fb0;
  logic         cin0, carry0, busy0, done0, pass0;
  logic [15:0]  err0;
  logic [2:0]   s0;

  // u2 / u3: adder with a two-stage output register
  logic [W-1:0] a2, b2, sum2, fa2, fb2;
  logic         cin2, carry2, busy2, done2, pass2;
  logic [15:0]  err2;
  logic [2:0]   p2a, p2b;

  logic [W-1:0] a3, b3, sum3, fa3, fb3;
  logic         cin3, carry3, busy3, done3, pass3;
  logic [15:0]  err3;
  logic [2:0]   p3a, p3b;

`ifndef ADDER_SWEEP_CIN_EN
  assign cin0 = 1'b0;
  assign cin2 = 1'b0;
  assign cin3 = 1'b0;
`endif

  // fault 1: carry stuck at 0, fault 2: carry-in ignored
  always_comb begin
    s0     = {1'b0, a0} + {1'b0, b0} + {2'b00, (fault == 2) ? 1'b0 : cin0};
    sum0   = s0[1:0];
    carry0 = (fault == 1) ? 1'b0 : s0[2];
  end

  always_ff @(posedge clk) begin
    p2a <= {1'b0, a2} + {1'b0, b2} + {2'b00, cin2};
    p2b <= p2a;
    p3a <= {1'b0, a3} + {1'b0, b3} + {2'b00, cin3};
    p3b <= p3a;
  end
  assign {carry2, sum2} = p2b;
  assign {carry3, sum3} = p3b;

  adder_sweep_checker #(.WIDTH(W), .DUT_LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .a(a0), .b(b0),
`ifdef ADDER_SWEEP_CIN_EN
    .cin(cin0),
`endif
    .sum(sum0), .carry(carry0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_a(fa0), .fail_b(fb0)
  );

  adder_sweep_checker #(.WIDTH(W), .DUT_LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .a(a2), .b(b2),
`ifdef ADDER_SWEEP_CIN_EN
    .cin(cin2),
`endif
    .sum(sum2), .carry(carry2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_a(fa2), .fail_b(fb2)
  );

  adder_sweep_checker #(.WIDTH(W), .DUT_LAT(0)) u3 (
    .clk(clk), .rst(rst), .start(start), .a(a3), .b(b3),
`ifdef ADDER_SWEEP_CIN_EN
    .cin(cin3),
`endif
    .sum(sum3), .carry(carry3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_a(fa3), .fail_b(fb3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      npass++;
  endtask

  // Pulses start and watches a bounded window, counting busy cycles and
  // done pulses. repulse re-asserts start at sweep cycles 3 and 10;
  // rst_at >= 0 applies reset at that cycle and checks the aftermath.
  task automatic run(input bit repulse, input int rst_at,
                     output int bc0, output int bc2, output int dc0, output int dc2);
    bc0 = 0; bc2 = 0; dc0 = 0; dc2 = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < NVEC * 3 + 10; c++) begin
      @(negedge clk);
      if (busy0) bc0++;
      if (busy2) bc2++;
      if (done0) dc0++;
      if (done2) dc2++;
      start = repulse && (c == 3 || c == 10);
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy0, 0);
        chk("rst_err",  err0,  0);
        chk("rst_a",    a0,    0);
        chk("rst_b",    b0,    0);
        chk("rst_done", done0, 0);
        break;
      end
    end
    start = 1'b0;
  endtask

  int bc0, bc2, dc0, dc2;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fault = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_pass", pass0, 0);
    chk("reset_err",  err0,  0);
    chk("reset_a",    a0,    0);
    chk("reset_fa",   fa0,   0);

    // correct adders
    run(1'b0, -1, bc0, bc2, dc0, dc2);
    chk("good_busy",   bc0,   NVEC);
    chk("good_done",   dc0,   1);
    chk("good_pass",   pass0, 1);
    chk("good_err",    err0,  0);
    chk("good_fa",     fa0,   0);
    chk("good_fb",     fb0,   0);
    chk("idle_a",      a0,    0);
    chk("idle_b",      b0,    0);
    chk("lat2_busy",   bc2,   NVEC * 3);
    chk("lat2_done",   dc2,   1);
    chk("lat2_pass",   pass2, 1);
    chk("lat2_err",    err2,  0);
    chk("lat0reg_pass", pass3, 0);

    // carry stuck at 0
    fault = 1;
    run(1'b0, -1, bc0, bc2, dc0, dc2);
    chk("stuck_err",  err0,  ERR_STUCK);
    chk("stuck_pass", pass0, 0);
    chk("stuck_fa",   fa0,   FA_STUCK);
    chk("stuck_fb",   fb0,   3);
    chk("stuck_busy", bc0,   NVEC);

    // start re-pulsed mid-sweep
    fault = 0;
    run(1'b1, -1, bc0, bc2, dc0, dc2);
    chk("repulse_busy",  bc0,   NVEC);
    chk("repulse_done",  dc0,   1);
    chk("repulse_pass",  pass0, 1);
    chk("repulse_busy2", bc2,   NVEC * 3);

    // reset mid-sweep with a faulty adder, then a full fresh sweep
    fault = 1;
    run(1'b0, 7, bc0, bc2, dc0, dc2);
    chk("rst_nodone", dc0, 0);
    run(1'b0, -1, bc0, bc2, dc0, dc2);
    chk("after_rst_busy", bc0,  NVEC);
    chk("after_rst_done", dc0,  1);
    chk("after_rst_err",  err0, ERR_STUCK);

`ifdef ADDER_SWEEP_CIN_EN
    // carry-in ignored inside the adder
    fault = 2;
    run(1'b0, -1, bc0, bc2, dc0, dc2);
    chk("cin0_err",  err0,  16);
    chk("cin0_pass", pass0, 0);
    chk("cin0_fa",   fa0,   0);
    chk("cin0_fb",   fb0,   0);
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
